// File: rtl/io_port_bridge.sv
// I/O bridge between the CPU's input_port/OUT/interrupt pins and external byte devices.
// Inbound bytes queue in an RX FIFO with an arrival interrupt; CPU OUT bytes queue in a TX FIFO.
module io_port_bridge #(
    parameter int DEPTH   = 4,
    parameter bit INTR_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ext_in_valid,
    input  logic [7:0]               ext_in_data,
    output logic                     ext_in_ready,
    output logic [7:0]               cpu_in_data,
    input  logic                     cpu_in_pop,
    output logic                     cpu_intr,
    input  logic                     cpu_out_valid,
    input  logic [7:0]               cpu_out_data,
    output logic                     ext_out_valid,
    output logic [7:0]               ext_out_data,
    input  logic                     ext_out_ready,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic                     tx_overflow,
    output logic [1:0]               intr_state_dbg
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRE  = 2'd1,
        ARMED = 2'd2
    } intr_state_t;

    // Handshakes: a byte moves on a cycle where valid and ready are both high at the
    // rising edge; ready comes only from registered occupancy, so a full FIFO refuses
    // a write even when a read happens in the same cycle.

    logic [7:0]    rx_mem_q [DEPTH];
    logic [PW-1:0] rx_wptr_q, rx_rptr_q;
    logic [CW-1:0] rx_count_q, rx_count_d;
    logic          rx_wr, rx_rd;

    logic [7:0]    tx_mem_q [DEPTH];
    logic [PW-1:0] tx_wptr_q, tx_rptr_q;
    logic [CW-1:0] tx_count_q, tx_count_d;
    logic          tx_wr, tx_rd, tx_full;
    logic          tx_overflow_q;

    intr_state_t   intr_state_q, intr_state_d;

    assign ext_in_ready = (rx_count_q != FULL);
    assign rx_wr        = ext_in_valid & ext_in_ready;
    assign rx_rd        = cpu_in_pop & (rx_count_q != '0);
    assign rx_count_d   = rx_count_q + CW'(rx_wr) - CW'(rx_rd);

    assign tx_full      = (tx_count_q == FULL);
    assign tx_wr        = cpu_out_valid & ~tx_full;
    assign tx_rd        = ext_out_valid & ext_out_ready;
    assign tx_count_d   = tx_count_q + CW'(tx_wr) - CW'(tx_rd);

    // Head bytes fall through combinationally and read as zero while empty.
    assign cpu_in_data   = (rx_count_q != '0) ? rx_mem_q[rx_rptr_q] : 8'h00;
    assign ext_out_valid = (tx_count_q != '0);
    assign ext_out_data  = ext_out_valid ? tx_mem_q[tx_rptr_q] : 8'h00;
    assign rx_count      = rx_count_q;
    assign tx_overflow   = tx_overflow_q;

    always_ff @(posedge clk) begin
        if (rx_wr) rx_mem_q[rx_wptr_q] <= ext_in_data;
        if (tx_wr) tx_mem_q[tx_wptr_q] <= cpu_out_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wptr_q     <= '0;
            rx_rptr_q     <= '0;
            rx_count_q    <= '0;
            tx_wptr_q     <= '0;
            tx_rptr_q     <= '0;
            tx_count_q    <= '0;
            tx_overflow_q <= 1'b0;
        end else begin
            if (rx_wr) rx_wptr_q <= rx_wptr_q + PW'(1);
            if (rx_rd) rx_rptr_q <= rx_rptr_q + PW'(1);
            rx_count_q <= rx_count_d;
            if (tx_wr) tx_wptr_q <= tx_wptr_q + PW'(1);
            if (tx_rd) tx_rptr_q <= tx_rptr_q + PW'(1);
            tx_count_q <= tx_count_d;
            if (cpu_out_valid && tx_full) tx_overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) intr_state_q <= IDLE;
        else       intr_state_q <= intr_state_d;
    end

    // FIRE also checks for emptiness so a pop in the pulse cycle cannot strand ARMED at zero.
    always_comb begin
        intr_state_d = intr_state_q;
        case (intr_state_q)
            IDLE:    if (INTR_EN && rx_wr && (rx_count_q == '0)) intr_state_d = FIRE;
            FIRE:    intr_state_d = (rx_count_d == '0) ? IDLE : ARMED;
            ARMED:   if (rx_count_d == '0) intr_state_d = IDLE;
            default: intr_state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_intr       = INTR_EN && (intr_state_q == FIRE);
        intr_state_dbg = intr_state_q;
    end
endmodule

// File: tb/tb_io_port_bridge.sv
// Bench for io_port_bridge: directed vector table, reset sequence, and randomized
// traffic checked every cycle against a queue-based model.
module tb_io_port_bridge;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       ext_in_valid;
    logic [7:0] ext_in_data;
    logic       ext_in_ready;
    logic [7:0] cpu_in_data;
    logic       cpu_in_pop;
    logic       cpu_intr;
    logic       cpu_out_valid;
    logic [7:0] cpu_out_data;
    logic       ext_out_valid;
    logic [7:0] ext_out_data;
    logic       ext_out_ready;
    logic [2:0] rx_count;
    logic       tx_overflow;
    logic [1:0] intr_state_dbg;

    always #5 clk = ~clk;

    io_port_bridge #(.DEPTH(DEPTH), .INTR_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .ext_in_valid(ext_in_valid), .ext_in_data(ext_in_data), .ext_in_ready(ext_in_ready),
        .cpu_in_data(cpu_in_data), .cpu_in_pop(cpu_in_pop), .cpu_intr(cpu_intr),
        .cpu_out_valid(cpu_out_valid), .cpu_out_data(cpu_out_data),
        .ext_out_valid(ext_out_valid), .ext_out_data(ext_out_data), .ext_out_ready(ext_out_ready),
        .rx_count(rx_count), .tx_overflow(tx_overflow), .intr_state_dbg(intr_state_dbg)
    );

    // Reference model: byte queues plus the two flags the DUT exposes.
    logic [7:0] exp_q[$];
    logic [7:0] tx_exp_q[$];
    bit         m_ovf;
    bit         m_intr;
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       pop;
        logic       ov;
        logic [7:0] od;
        logic       ordy;
        logic [2:0] e_cnt;
        logic [7:0] e_head;
        logic       e_intr;
        logic       e_rdy;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_ovf;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model ext_in_ready", 32'(ext_in_ready), 32'(exp_q.size() < DEPTH));
        chk("model cpu_in_data", 32'(cpu_in_data), 32'((exp_q.size() != 0) ? exp_q[0] : 8'h00));
        chk("model rx_count", 32'(rx_count), 32'(exp_q.size()));
        chk("model cpu_intr", 32'(cpu_intr), 32'(m_intr));
        chk("model ext_out_valid", 32'(ext_out_valid), 32'(tx_exp_q.size() != 0));
        chk("model ext_out_data", 32'(ext_out_data), 32'((tx_exp_q.size() != 0) ? tx_exp_q[0] : 8'h00));
        chk("model tx_overflow", 32'(tx_overflow), 32'(m_ovf));
    endtask

    // Called at a falling edge: drive inputs, advance one rising edge, check at the next falling edge.
    task automatic cycle(input logic rst, input logic iv, input logic [7:0] id, input logic pop,
                         input logic ov, input logic [7:0] od, input logic ordy);
        bit rx_wr, rx_rd, tx_wr, tx_rd, fire, ovf_set;
        reset = rst; ext_in_valid = iv; ext_in_data = id; cpu_in_pop = pop;
        cpu_out_valid = ov; cpu_out_data = od; ext_out_ready = ordy;
        rx_wr   = iv && (exp_q.size() < DEPTH);
        rx_rd   = pop && (exp_q.size() != 0);
        fire    = rx_wr && (exp_q.size() == 0);
        tx_wr   = ov && (tx_exp_q.size() < DEPTH);
        ovf_set = ov && (tx_exp_q.size() == DEPTH);
        tx_rd   = ordy && (tx_exp_q.size() != 0);
        @(posedge clk);
        if (rst) begin
            exp_q.delete(); tx_exp_q.delete(); m_ovf = 1'b0; m_intr = 1'b0;
        end else begin
            if (rx_rd) void'(exp_q.pop_front());
            if (rx_wr) exp_q.push_back(id);
            if (tx_rd) void'(tx_exp_q.pop_front());
            if (tx_wr) tx_exp_q.push_back(od);
            if (ovf_set) m_ovf = 1'b1;
            m_intr = fire;
        end
        @(negedge clk);
        check_model();
    endtask

    function automatic vec_t rxv(input logic iv, input logic [7:0] id, input logic pop,
                                 input logic [2:0] e_cnt, input logic [7:0] e_head,
                                 input logic e_intr, input logic e_rdy);
        vec_t v;
        v.iv = iv; v.id = id; v.pop = pop; v.ov = 1'b0; v.od = 8'h00; v.ordy = 1'b0;
        v.e_cnt = e_cnt; v.e_head = e_head; v.e_intr = e_intr; v.e_rdy = e_rdy;
        v.e_ov = 1'b0; v.e_od = 8'h00; v.e_ovf = 1'b0;
        return v;
    endfunction

    function automatic vec_t txv(input logic ov, input logic [7:0] od, input logic ordy,
                                 input logic e_ov, input logic [7:0] e_od, input logic e_ovf);
        vec_t v;
        v.iv = 1'b0; v.id = 8'h00; v.pop = 1'b0; v.ov = ov; v.od = od; v.ordy = ordy;
        v.e_cnt = 3'd0; v.e_head = 8'h00; v.e_intr = 1'b0; v.e_rdy = 1'b1;
        v.e_ov = e_ov; v.e_od = e_od; v.e_ovf = e_ovf;
        return v;
    endfunction

    initial begin
        // Push/pop ordering and interrupt pulses.
        vq.push_back(rxv(1'b1, 8'h11, 1'b0, 3'd1, 8'h11, 1'b1, 1'b1));
        vq.push_back(rxv(1'b1, 8'h22, 1'b0, 3'd2, 8'h11, 1'b0, 1'b1));
        vq.push_back(rxv(1'b1, 8'h33, 1'b0, 3'd3, 8'h11, 1'b0, 1'b1));
        vq.push_back(rxv(1'b0, 8'h00, 1'b1, 3'd2, 8'h22, 1'b0, 1'b1));
        vq.push_back(rxv(1'b0, 8'h00, 1'b1, 3'd1, 8'h33, 1'b0, 1'b1));
        vq.push_back(rxv(1'b0, 8'h00, 1'b1, 3'd0, 8'h00, 1'b0, 1'b1));
        vq.push_back(rxv(1'b1, 8'h44, 1'b0, 3'd1, 8'h44, 1'b1, 1'b1));
        vq.push_back(rxv(1'b0, 8'h00, 1'b1, 3'd0, 8'h00, 1'b0, 1'b1));
        // Fill to full, refused write, pop-while-full, wrap.
        vq.push_back(rxv(1'b1, 8'hA0, 1'b0, 3'd1, 8'hA0, 1'b1, 1'b1));
        vq.push_back(rxv(1'b1, 8'hA1, 1'b0, 3'd2, 8'hA0, 1'b0, 1'b1));
        vq.push_back(rxv(1'b1, 8'hA2, 1'b0, 3'd3, 8'hA0, 1'b0, 1'b1));
        vq.push_back(rxv(1'b1, 8'hA3, 1'b0, 3'd4, 8'hA0, 1'b0, 1'b0));
        vq.push_back(rxv(1'b1, 8'hA4, 1'b0, 3'd4, 8'hA0, 1'b0, 1'b0));
        vq.push_back(rxv(1'b1, 8'hA4, 1'b1, 3'd3, 8'hA1, 1'b0, 1'b1));
        vq.push_back(rxv(1'b1, 8'hA4, 1'b0, 3'd4, 8'hA1, 1'b0, 1'b0));
        vq.push_back(rxv(1'b0, 8'h00, 1'b1, 3'd3, 8'hA2, 1'b0, 1'b1));
        vq.push_back(rxv(1'b0, 8'h00, 1'b1, 3'd2, 8'hA3, 1'b0, 1'b1));
        vq.push_back(rxv(1'b0, 8'h00, 1'b1, 3'd1, 8'hA4, 1'b0, 1'b1));
        vq.push_back(rxv(1'b0, 8'h00, 1'b1, 3'd0, 8'h00, 1'b0, 1'b1));
        // Simultaneous push and pop at count 2, then pop on empty.
        vq.push_back(rxv(1'b1, 8'h01, 1'b0, 3'd1, 8'h01, 1'b1, 1'b1));
        vq.push_back(rxv(1'b1, 8'h02, 1'b0, 3'd2, 8'h01, 1'b0, 1'b1));
        vq.push_back(rxv(1'b1, 8'h55, 1'b1, 3'd2, 8'h02, 1'b0, 1'b1));
        vq.push_back(rxv(1'b0, 8'h00, 1'b1, 3'd1, 8'h55, 1'b0, 1'b1));
        vq.push_back(rxv(1'b0, 8'h00, 1'b1, 3'd0, 8'h00, 1'b0, 1'b1));
        vq.push_back(rxv(1'b0, 8'h00, 1'b1, 3'd0, 8'h00, 1'b0, 1'b1));
        // TX fill with overflow, then drain.
        vq.push_back(txv(1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0));
        vq.push_back(txv(1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b0));
        vq.push_back(txv(1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 1'b0));
        vq.push_back(txv(1'b1, 8'h04, 1'b0, 1'b1, 8'h01, 1'b0));
        vq.push_back(txv(1'b1, 8'h05, 1'b0, 1'b1, 8'h01, 1'b1));
        vq.push_back(txv(1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b1));
        vq.push_back(txv(1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b1));
        vq.push_back(txv(1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 1'b1));
        vq.push_back(txv(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1));
        vq.push_back(txv(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1));

        // Reset, then idle.
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("idle ext_in_ready", 32'(ext_in_ready), 32'd1);
        chk("idle ext_out_valid", 32'(ext_out_valid), 32'd0);
        chk("idle ext_out_data", 32'(ext_out_data), 32'd0);
        chk("idle cpu_in_data", 32'(cpu_in_data), 32'd0);
        chk("idle cpu_intr", 32'(cpu_intr), 32'd0);
        chk("idle rx_count", 32'(rx_count), 32'd0);
        chk("idle tx_overflow", 32'(tx_overflow), 32'd0);

        foreach (vq[i]) begin
            cycle(1'b0, vq[i].iv, vq[i].id, vq[i].pop, vq[i].ov, vq[i].od, vq[i].ordy);
            chk($sformatf("v%0d rx_count", i), 32'(rx_count), 32'(vq[i].e_cnt));
            chk($sformatf("v%0d cpu_in_data", i), 32'(cpu_in_data), 32'(vq[i].e_head));
            chk($sformatf("v%0d cpu_intr", i), 32'(cpu_intr), 32'(vq[i].e_intr));
            chk($sformatf("v%0d ext_in_ready", i), 32'(ext_in_ready), 32'(vq[i].e_rdy));
            chk($sformatf("v%0d ext_out_valid", i), 32'(ext_out_valid), 32'(vq[i].e_ov));
            chk($sformatf("v%0d ext_out_data", i), 32'(ext_out_data), 32'(vq[i].e_od));
            chk($sformatf("v%0d tx_overflow", i), 32'(tx_overflow), 32'(vq[i].e_ovf));
        end

        // Reset while RX holds three bytes with the interrupt armed and overflow sticky.
        cycle(1'b0, 1'b1, 8'h61, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 8'h62, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 8'h63, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("pre-reset rx_count", 32'(rx_count), 32'd3);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("post-reset rx_count", 32'(rx_count), 32'd0);
        chk("post-reset tx_overflow", 32'(tx_overflow), 32'd0);
        chk("post-reset cpu_in_data", 32'(cpu_in_data), 32'd0);
        cycle(1'b0, 1'b1, 8'h70, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("fresh pulse cpu_intr", 32'(cpu_intr), 32'd1);
        chk("fresh pulse cpu_in_data", 32'(cpu_in_data), 32'h70);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("fresh pulse ends", 32'(cpu_intr), 32'd0);

        // Randomized traffic, model-checked every cycle.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 199) == 0),
                  1'($urandom_range(0, 99) < 60), 8'($urandom),
                  1'($urandom_range(0, 99) < 45),
                  1'($urandom_range(0, 99) < 30), 8'($urandom),
                  1'($urandom_range(0, 99) < 50));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/io_port_bridge.md
Name: io_port_bridge

Overview:
- Sits between the 8-bit pipelined CPU's I/O pins and external devices: the opposite end of the CPU's input_port, OUT and interrupt interface.
- Inbound: buffers bytes from an external producer in an RX FIFO, presents the head byte on cpu_in_data (drives the CPU input_port), and pulses cpu_intr when data arrives.
- Outbound: captures CPU OUT writes into a TX FIFO and drains them to an external consumer over a valid/ready handshake.

Parameters:
- DEPTH, 4, entries per FIFO; power of 2, minimum 2.
- INTR_EN, 1, 1 enables cpu_intr generation; 0 ties cpu_intr low.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ext_in_valid  input  1  external producer offers ext_in_data.
- ext_in_data  input  8  inbound byte.
- ext_in_ready  output  1  RX FIFO not full.
- cpu_in_data  output  8  RX head byte; drives CPU input_port; 0 when RX is empty.
- cpu_in_pop  input  1  CPU consumed the head byte (IN executed); one-cycle pulse.
- cpu_intr  output  1  one-cycle interrupt request to the CPU.
- cpu_out_valid  input  1  CPU OUT instruction in EX this cycle.
- cpu_out_data  input  8  CPU OUT byte.
- ext_out_valid  output  1  TX FIFO not empty.
- ext_out_data  output  8  TX head byte.
- ext_out_ready  input  1  external consumer accepts the byte.
- rx_count  output  log2(DEPTH)+1  RX occupancy.
- tx_overflow  output  1  sticky: a CPU OUT byte was dropped because TX was full.

Behaviour:
- Reset: both FIFOs empty, pointers 0. Outputs: ext_in_ready=1, cpu_in_data=0, cpu_intr=0, ext_out_valid=0, ext_out_data=0, rx_count=0, tx_overflow=0. Reset mid-transfer discards all buffered data; intr FSM returns to IDLE.
- FIFO structure: each FIFO uses a pointer ring of width log2(DEPTH) that wraps from DEPTH-1 to 0, plus a count register. Head data is combinational from storage (first-word fall-through).
  - RX write: ext_in_valid & ext_in_ready.
  - RX read: cpu_in_pop & (rx_count != 0).
  - TX write: cpu_out_valid.
  - TX read: ext_out_valid & ext_out_ready.
- Simultaneous read and write on the same FIFO:
  - Not full and not empty: both happen; count unchanged.
  - When full, a write is refused even if a read occurs the same cycle (ready is computed from registered count, with no bypass).
  - When empty, the read is ignored and the write occurs.
- Pop on empty RX: ignored; no pointer or count change.
- Write latency: a byte written at edge N is visible on cpu_in_data / ext_out_data after edge N (available in cycle N+1).
- TX full with cpu_out_valid=1: byte dropped, tx_overflow set to 1 and held until reset. The CPU is never back-pressured.
- Interrupt FSM (INTR_EN=1):
  - IDLE: when an RX write occurs with rx_count==0, go to FIRE.
  - FIRE: cpu_intr=1 for exactly one cycle, then go to ARMED.
  - ARMED: cpu_intr=0. Return to IDLE when rx_count reaches 0 (after a pop that empties RX). Further writes while in ARMED produce no new pulse.
  - Pop-to-empty and write in the same cycle: stay in ARMED (count stays nonzero), no pulse.
  - Each transition of RX from empty to non-empty yields exactly one pulse.
- Count arithmetic: unsigned, width log2(DEPTH)+1. Never exceeds DEPTH and never goes below 0.

Test Plan:
- Reset then idle 5 cycles -> ext_in_ready=1, ext_out_valid=0, cpu_in_data=0, cpu_intr=0, rx_count=0.
- Push 0x11 at edge N -> cpu_intr=1 only in cycle N+1, cpu_in_data=0x11. Push 0x22, 0x33 -> no further pulse. Pop three times -> data order 0x11, 0x22, 0x33, rx_count=0. Push 0x44 -> new single pulse.
- Push 5 bytes (0xA0..0xA4) with no pops, DEPTH=4 -> ext_in_ready=0 after the 4th; 0xA4 held off; rx_count=4. One pop with ext_in_valid high -> 0xA4 accepted the following cycle. FIFO order preserved across pointer wrap.
- With ext_out_ready=0, CPU OUT 0x01..0x05 -> TX holds 0x01..0x04, tx_overflow=1. Raise ext_out_ready -> ext_out_data sequence 0x01, 0x02, 0x03, 0x04, then ext_out_valid=0.
- RX at count 2, same-cycle push 0x55 and pop -> rx_count stays 2; head advances; 0x55 appears last. Pop on empty RX -> no change.
- Reset asserted while RX holds 3 bytes and cpu_intr is ARMED -> next cycle rx_count=0, tx_overflow=0. A subsequent push produces a fresh cpu_intr pulse.
